// File: rtl/if_stage_ext.sv
// if_stage_ext - parametrised MIPS instruction-fetch stage.
//
// Holds the PC and a loadable instruction memory, and drives the IF/ID
// pipeline register. Supports single-step debug fetch, halt-word detection,
// flush on branch/jump redirect, and a saturating fetch counter.
//
// Ports:
//   i_clk, i_reset      clock (rising edge), asynchronous active-high reset
//   i_run_mode          1 = continuous fetch, 0 = single-step
//   i_step              step request level; each rising edge grants one advance
//   i_stall             hazard stall; holds PC and IF/ID
//   i_pcsrc, i_beq_dir  branch taken / branch target
//   i_jump, i_jump_dir  jump taken / jump target (wins over branch)
//   i_write_en, i_addr_wr, i_data   loader write port (byte address)
//   o_pc                current PC
//   o_pc_plus_4, o_instruction      IF/ID register contents
//   o_flush             combinational; high when this edge applies a redirect
//   o_halted            fetch halted (cleared only by reset)
//   o_fetch_count       number of valid instructions latched (saturating)
module if_stage_ext #(
  parameter int                ADDR_W     = 32,
  parameter int                IMEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] PC_RESET   = '0,
  parameter logic [31:0]       HALT_WORD  = 32'hFFFF_FFFF,
  parameter int                CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run_mode,
  input  logic              i_step,
  input  logic              i_stall,
  input  logic              i_pcsrc,
  input  logic [ADDR_W-1:0] i_beq_dir,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_dir,
  input  logic              i_write_en,
  input  logic [ADDR_W-1:0] i_addr_wr,
  input  logic [31:0]       i_data,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus_4,
  output logic [31:0]       o_instruction,
  output logic              o_flush,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_fetch_count
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);

  logic [31:0]       imem [IMEM_DEPTH];

  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] pc_plus_4_p1;
  logic [31:0]       instr_p1;
  logic              halted;
  logic              step_q;
  logic [CNT_W-1:0]  fetch_cnt;

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              rd_oob;
  logic              wr_oob;
  logic [31:0]       fetch_word;
  logic [ADDR_W-1:0] pc_next_seq;
  logic              step_ok;
  logic              adv;
  logic              redirect;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] v);
    pc_inc = v + ADDR_W'(4);
  endfunction

  // Word index is PC[IDX_W+1:2]; any set bit above that field is outside
  // the memory and reads as the halt word so a runaway PC stops fetch.
  assign rd_idx = pc_p0[IDX_W+1:2];
  assign wr_idx = i_addr_wr[IDX_W+1:2];
  assign rd_oob = |(pc_p0 >> (IDX_W + 2));
  assign wr_oob = |(i_addr_wr >> (IDX_W + 2));

  assign fetch_word  = rd_oob ? HALT_WORD : imem[rd_idx];
  assign pc_next_seq = pc_inc(pc_p0);

  // step_q samples i_step every cycle, so a held step grants one advance.
  assign step_ok  = i_run_mode | (i_step & ~step_q);
  assign adv      = ~halted & ~i_write_en & ~i_stall & step_ok;
  assign redirect = i_jump | i_pcsrc;
  assign o_flush  = adv & redirect;

  // Loader write port; gated by reset so a write racing reset is dropped.
  always_ff @(posedge i_clk) begin
    if (i_write_en && !wr_oob && !i_reset) begin
      imem[wr_idx] <= i_data;
    end
  end

  // Stage p0 -> p1: PC update and IF/ID latch
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_p0        <= PC_RESET;
      pc_plus_4_p1 <= '0;
      instr_p1     <= '0;
      halted       <= 1'b0;
      step_q       <= 1'b0;
      fetch_cnt    <= '0;
    end else begin
      step_q <= i_step;
      if (adv) begin
        if (redirect) begin
          // Redirect beats a halt word fetched in the same cycle.
          pc_p0        <= i_jump ? i_jump_dir : i_beq_dir;
          pc_plus_4_p1 <= '0;
          instr_p1     <= '0;
        end else begin
          pc_plus_4_p1 <= pc_next_seq;
          instr_p1     <= fetch_word;
          fetch_cnt    <= sat_inc(fetch_cnt);
          if (fetch_word == HALT_WORD) begin
            halted <= 1'b1;
          end else begin
            pc_p0 <= pc_next_seq;
          end
        end
      end
    end
  end

  assign o_pc          = pc_p0;
  assign o_pc_plus_4   = pc_plus_4_p1;
  assign o_instruction = instr_p1;
  assign o_halted      = halted;
  assign o_fetch_count = fetch_cnt;

endmodule

// File: tb/tb_if_stage_ext.sv
module tb_if_stage_ext;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] FAR_PC = 32'h0000_1000;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_run_mode = 1'b0;
  logic        i_step = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_pcsrc = 1'b0;
  logic [31:0] i_beq_dir = '0;
  logic        i_jump = 1'b0;
  logic [31:0] i_jump_dir = '0;
  logic        i_write_en = 1'b0;
  logic [31:0] i_addr_wr = '0;
  logic [31:0] i_data = '0;

  logic [31:0] o_pc, o_pc_plus_4, o_instruction;
  logic        o_flush, o_halted;
  logic [15:0] o_fetch_count;

  logic [31:0] d2_pc, d2_pc_plus_4, d2_instruction;
  logic        d2_flush, d2_halted;
  logic [15:0] d2_fetch_count;

  int vec = 0;
  int err = 0;

  // reference model state
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_p4, m_ins;
  logic        m_halt, m_stepq;
  logic [15:0] m_cnt;
  logic        exp_flush, obs_flush;

  if_stage_ext dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_run_mode(i_run_mode), .i_step(i_step),
    .i_stall(i_stall), .i_pcsrc(i_pcsrc), .i_beq_dir(i_beq_dir), .i_jump(i_jump),
    .i_jump_dir(i_jump_dir), .i_write_en(i_write_en), .i_addr_wr(i_addr_wr),
    .i_data(i_data), .o_pc(o_pc), .o_pc_plus_4(o_pc_plus_4),
    .o_instruction(o_instruction), .o_flush(o_flush), .o_halted(o_halted),
    .o_fetch_count(o_fetch_count)
  );

  if_stage_ext #(.PC_RESET(FAR_PC)) dut_far (
    .i_clk(i_clk), .i_reset(i_reset), .i_run_mode(i_run_mode), .i_step(i_step),
    .i_stall(i_stall), .i_pcsrc(i_pcsrc), .i_beq_dir(i_beq_dir), .i_jump(i_jump),
    .i_jump_dir(i_jump_dir), .i_write_en(i_write_en), .i_addr_wr(i_addr_wr),
    .i_data(i_data), .o_pc(d2_pc), .o_pc_plus_4(d2_pc_plus_4),
    .o_instruction(d2_instruction), .o_flush(d2_flush), .o_halted(d2_halted),
    .o_fetch_count(d2_fetch_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic mreset();
    m_pc = 32'd0; m_p4 = '0; m_ins = '0; m_halt = 1'b0; m_stepq = 1'b0; m_cnt = '0;
  endtask

  // Advance one clock; the model applies the fetch-stage rules at the edge.
  task automatic tick();
    logic [31:0] fw;
    logic        adv;
    if (i_reset) mreset();
    fw = (m_pc >= 32'd1024) ? HALT : m_mem[m_pc / 4];
    adv = !m_halt && !i_write_en && !i_stall && (i_run_mode || (i_step && !m_stepq));
    exp_flush = adv && (i_jump || i_pcsrc);
    @(negedge i_clk);
    obs_flush = o_flush;
    @(posedge i_clk);
    if (i_reset) mreset();
    else begin
      if (i_write_en && i_addr_wr < 32'd1024) m_mem[i_addr_wr / 4] = i_data;
      if (adv) begin
        if (i_jump || i_pcsrc) begin
          m_pc = i_jump ? i_jump_dir : i_beq_dir;
          m_ins = '0; m_p4 = '0;
        end else begin
          m_ins = fw; m_p4 = m_pc + 32'd4;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (fw == HALT) m_halt = 1'b1;
          else m_pc = m_pc + 32'd4;
        end
      end
      m_stepq = i_step;
    end
    #1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    i_write_en = 1'b1; i_addr_wr = a; i_data = d;
    tick();
    i_write_en = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    #1 i_reset = 1'b1;
    mreset();
    #1;
    vec++; if (o_pc !== 32'd0) begin err++; $display("FAIL reset_pc got %h want %h", o_pc, 32'd0); end
    vec++; if (o_pc_plus_4 !== 32'd0 || o_instruction !== 32'd0) begin err++;
      $display("FAIL reset_ifid got %h/%h want 0/0", o_pc_plus_4, o_instruction); end
    vec++; if (o_halted !== 1'b0 || o_fetch_count !== 16'd0) begin err++;
      $display("FAIL reset_ctl got %b/%0d want 0/0", o_halted, o_fetch_count); end
    vec++; if (d2_pc !== FAR_PC) begin err++; $display("FAIL reset_far_pc got %h want %h", d2_pc, FAR_PC); end
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w == HALT) w = 32'h0;
      write_word(i * 4, w);
    end
    write_word(32'd0, 32'h2008_0005);
    write_word(32'd4, 32'h2009_000A);
    write_word(32'd8, 32'h200A_000F);
    vec++; if (o_pc !== 32'd0 || o_fetch_count !== 16'd0) begin err++;
      $display("FAIL load_hold got pc %h cnt %0d want 0/0", o_pc, o_fetch_count); end
  endtask

  task automatic test_load_run();
    logic [31:0] exp_ins [3];
    exp_ins[0] = 32'h2008_0005; exp_ins[1] = 32'h2009_000A; exp_ins[2] = 32'h200A_000F;
    i_run_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vec++; if (o_instruction !== exp_ins[k]) begin err++;
        $display("FAIL run_ins%0d got %h want %h", k, o_instruction, exp_ins[k]); end
      vec++; if (o_pc_plus_4 !== 32'(4 * (k + 1))) begin err++;
        $display("FAIL run_p4_%0d got %h want %h", k, o_pc_plus_4, 32'(4 * (k + 1))); end
      if (k == 0) begin
        vec++; if (d2_halted !== 1'b1 || d2_pc !== FAR_PC || d2_instruction !== HALT || d2_fetch_count !== 16'd1) begin
          err++; $display("FAIL far_halt got h%b pc %h ins %h cnt %0d want 1 %h %h 1",
                          d2_halted, d2_pc, d2_instruction, d2_fetch_count, FAR_PC, HALT); end
      end
    end
    vec++; if (o_fetch_count !== 16'd3) begin err++; $display("FAIL run_cnt got %0d want 3", o_fetch_count); end
  endtask

  task automatic test_branch();
    i_pcsrc = 1'b1; i_beq_dir = 32'd12;
    tick();
    i_pcsrc = 1'b0;
    vec++; if (obs_flush !== 1'b1) begin err++; $display("FAIL br_flush got %b want 1", obs_flush); end
    vec++; if (o_instruction !== 32'd0 || o_pc !== 32'd12 || o_fetch_count !== 16'd3) begin err++;
      $display("FAIL br_nop got ins %h pc %h cnt %0d want 0 c 3", o_instruction, o_pc, o_fetch_count); end
    tick();
    vec++; if (o_instruction !== m_mem[3] || o_pc_plus_4 !== 32'd16) begin err++;
      $display("FAIL br_after got %h/%h want %h/10", o_instruction, o_pc_plus_4, m_mem[3]); end
  endtask

  task automatic test_jump_priority();
    logic [15:0] c0;
    c0 = m_cnt;
    i_jump = 1'b1; i_jump_dir = 32'd16; i_pcsrc = 1'b1; i_beq_dir = 32'd8;
    tick();
    i_jump = 1'b0; i_pcsrc = 1'b0;
    vec++; if (obs_flush !== 1'b1) begin err++; $display("FAIL jmp_flush got %b want 1", obs_flush); end
    vec++; if (o_pc !== 32'd16 || o_fetch_count !== c0 || o_instruction !== 32'd0) begin err++;
      $display("FAIL jmp_prio got pc %h cnt %0d ins %h want 10 %0d 0", o_pc, o_fetch_count, o_instruction, c0); end
    tick();
    vec++; if (o_instruction !== m_mem[4] || o_pc !== 32'd20) begin err++;
      $display("FAIL jmp_after got %h pc %h want %h 14", o_instruction, o_pc, m_mem[4]); end
  endtask

  task automatic test_stall();
    logic [31:0] pc0, ins0;
    logic [15:0] c0;
    pc0 = o_pc; ins0 = m_ins; c0 = m_cnt;
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin i_pcsrc = 1'b1; i_beq_dir = 32'd0; end
      tick();
      vec++; if (obs_flush !== 1'b0) begin err++; $display("FAIL stall_flush%0d got %b want 0", k, obs_flush); end
      vec++; if (o_pc !== pc0 || o_instruction !== ins0 || o_fetch_count !== c0) begin err++;
        $display("FAIL stall_hold%0d got %h %h %0d want %h %h %0d", k, o_pc, o_instruction, o_fetch_count, pc0, ins0, c0); end
    end
    i_stall = 1'b0;
    tick();
    i_pcsrc = 1'b0;
    vec++; if (obs_flush !== 1'b1 || o_pc !== 32'd0) begin err++;
      $display("FAIL stall_release got flush %b pc %h want 1 0", obs_flush, o_pc); end
  endtask

  task automatic test_step();
    logic [31:0] exp_pc [8];
    logic        stp [8];
    i_run_mode = 1'b0; i_step = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      stp[k] = (k < 5 || k > 5);
      exp_pc[k] = (k < 6) ? 32'd4 : 32'd8;
    end
    for (int k = 0; k < 8; k++) begin
      i_step = stp[k];
      tick();
      vec++; if (o_pc !== exp_pc[k] || o_pc !== m_pc) begin err++;
        $display("FAIL step_pc%0d got %h want %h", k, o_pc, exp_pc[k]); end
    end
    i_step = 1'b0;
    vec++; if (o_fetch_count !== 16'd2) begin err++; $display("FAIL step_cnt got %0d want 2", o_fetch_count); end
  endtask

  task automatic test_halt();
    logic [15:0] c0;
    write_word(32'd8, HALT);
    i_run_mode = 1'b1;
    tick();
    vec++; if (o_halted !== 1'b1 || o_pc !== 32'd8 || o_instruction !== HALT || o_pc_plus_4 !== 32'd12) begin err++;
      $display("FAIL halt_set got h%b pc %h ins %h p4 %h want 1 8 %h c", o_halted, o_pc, o_instruction, o_pc_plus_4, HALT); end
    c0 = m_cnt;
    i_jump = 1'b1; i_jump_dir = 32'd0; i_pcsrc = 1'b1; i_beq_dir = 32'd4;
    tick(); tick();
    i_jump = 1'b0; i_pcsrc = 1'b0;
    vec++; if (obs_flush !== 1'b0 || o_pc !== 32'd8 || o_fetch_count !== c0) begin err++;
      $display("FAIL halt_hold got flush %b pc %h cnt %0d want 0 8 %0d", obs_flush, o_pc, o_fetch_count, c0); end
  endtask

  task automatic test_reset_write();
    i_write_en = 1'b1; i_addr_wr = 32'd0; i_data = 32'hDEAD_BEEF;
    i_reset = 1'b1;
    #1;
    vec++; if (o_halted !== 1'b0 || o_pc !== 32'd0 || o_fetch_count !== 16'd0) begin err++;
      $display("FAIL async_clear got h%b pc %h cnt %0d want 0 0 0", o_halted, o_pc, o_fetch_count); end
    tick();
    i_write_en = 1'b0;
    i_reset = 1'b0;
    tick();
    vec++; if (o_instruction !== 32'h2008_0005 || o_pc !== 32'd4) begin err++;
      $display("FAIL mem_retained got %h pc %h want 20080005 4", o_instruction, o_pc); end
    tick(); tick();
    vec++; if (o_halted !== 1'b1 || o_instruction !== HALT) begin err++;
      $display("FAIL rehalt got h%b ins %h want 1 %h", o_halted, o_instruction, HALT); end
  endtask

  task automatic test_random();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    for (int n = 0; n < 600; n++) begin
      i_reset    = ($urandom_range(0, 39) == 0);
      i_write_en = ($urandom_range(0, 7) == 0);
      i_addr_wr  = $urandom_range(0, 1100);
      i_data     = ($urandom_range(0, 5) == 0) ? HALT : $urandom;
      i_stall    = ($urandom_range(0, 4) == 0);
      i_run_mode = ($urandom_range(0, 9) < 7);
      i_step     = $urandom_range(0, 1);
      i_jump     = ($urandom_range(0, 9) == 0);
      i_jump_dir = $urandom_range(0, 1100);
      i_pcsrc    = ($urandom_range(0, 7) == 0);
      i_beq_dir  = $urandom_range(0, 1100);
      tick();
      vec++; if (obs_flush !== exp_flush) begin err++; $display("FAIL rnd_flush n=%0d got %b want %b", n, obs_flush, exp_flush); end
      vec++; if (o_pc !== m_pc) begin err++; $display("FAIL rnd_pc n=%0d got %h want %h", n, o_pc, m_pc); end
      vec++; if (o_pc_plus_4 !== m_p4) begin err++; $display("FAIL rnd_p4 n=%0d got %h want %h", n, o_pc_plus_4, m_p4); end
      vec++; if (o_instruction !== m_ins) begin err++; $display("FAIL rnd_ins n=%0d got %h want %h", n, o_instruction, m_ins); end
      vec++; if (o_halted !== m_halt) begin err++; $display("FAIL rnd_halt n=%0d got %b want %b", n, o_halted, m_halt); end
      vec++; if (o_fetch_count !== m_cnt) begin err++; $display("FAIL rnd_cnt n=%0d got %0d want %0d", n, o_fetch_count, m_cnt); end
    end
    i_reset = 1'b0; i_write_en = 1'b0; i_stall = 1'b0; i_jump = 1'b0; i_pcsrc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_load_run();
    test_branch();
    test_jump_priority();
    test_stall();
    test_step();
    test_halt();
    test_reset_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
